// File: rtl/safe_lock_controller.sv
// Digital safe control FSM: entry buffer, stored password, verify/set/open/fail/lock sequencing.
// Optional feature macro: LOCKOUT_EN (tracks consecutive failures and enables the LOCK state).
module safe_lock_controller #(
  parameter int RESULT_TICKS = 500,
  parameter int MAX_FAIL     = 3,
  parameter int LOCK_TICKS   = 3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_100hz,
  input  logic        up_p,
  input  logic        down_p,
  input  logic        slide_p,
  input  logic        place,
  input  logic        pw_set,
  input  logic        pw_endset_p,
  input  logic        ok_p,
  output logic [15:0] disp_digits,
  output logic [1:0]  cursor,
  output logic        led_g,
  output logic        led_r,
  output logic [2:0]  state,
  output logic [1:0]  fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_OPEN     = 3'd1,
    S_SET      = 3'd2,
    S_SET_WAIT = 3'd3,
    S_FAIL     = 3'd4,
    S_LOCK     = 3'd5
  } state_t;

  localparam logic [11:0] RESULT_LAST = 12'(RESULT_TICKS - 1);
  localparam logic [11:0] LOCK_LAST   = 12'(LOCK_TICKS - 1);

  state_t      r_state, w_state_next;
  logic [15:0] r_digits, w_digits_next, w_edit_digits;
  logic [15:0] r_pw, w_pw_next;
  logic        r_half, w_half_next;
  logic        r_place;
  logic [11:0] r_timer, w_timer_next;
  logic [1:0]  r_fail_cnt, w_fail_next, w_fail_inc;
  logic        r_led_g, r_led_r;
  logic [1:0]  w_sel;
  logic        w_res_exp, w_lock_exp, w_lock_due;

  assign w_sel      = {place, r_half};
  assign w_res_exp  = tick_100hz && (r_timer == RESULT_LAST);
  assign w_lock_exp = tick_100hz && (r_timer == LOCK_LAST);
  assign w_lock_due = (int'(r_fail_cnt) >= MAX_FAIL);

`ifdef LOCKOUT_EN
  assign w_fail_inc = (r_fail_cnt == 2'd3) ? 2'd3 : r_fail_cnt + 2'd1;
`else
  // Without lockout the counter never leaves zero, so FAIL always returns to IDLE.
  assign w_fail_inc = 2'd0;
`endif

  // Edited copy of the buffer; only the selected digit moves, the rest pass through.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] w_d;
      assign w_d = r_digits[4*gi+3 -: 4];
      assign w_edit_digits[4*gi+3 -: 4] =
        (w_sel != 2'(gi)) ? w_d :
        up_p              ? ((w_d >= 4'd9) ? 4'd0 : w_d + 4'd1) :
                            ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);
    end
  endgenerate

  always_comb begin
    w_state_next  = r_state;
    w_digits_next = r_digits;
    w_pw_next     = r_pw;
    w_half_next   = r_half;
    w_fail_next   = r_fail_cnt;
    case (r_state)
      S_IDLE: begin
        if (ok_p) begin
          if (r_digits == r_pw) begin
            w_state_next = S_OPEN;
            w_fail_next  = 2'd0;
          end else begin
            w_state_next = S_FAIL;
            w_fail_next  = w_fail_inc;
          end
          w_digits_next = 16'h0000;
          w_half_next   = 1'b0;
        end else if (slide_p) begin
          w_half_next = ~r_half;
        end else if (up_p ^ down_p) begin
          w_digits_next = w_edit_digits;
        end
      end
      S_OPEN: begin
        if (w_res_exp)   w_state_next = S_IDLE;
        else if (pw_set) w_state_next = S_SET;
      end
      S_SET: begin
        // A commit in the same clock as pw_set dropping still counts as a commit.
        if (pw_endset_p) begin
          w_pw_next     = r_digits;
          w_digits_next = 16'h0000;
          w_fail_next   = 2'd0;
          w_state_next  = S_SET_WAIT;
        end else if (!pw_set) begin
          w_state_next = S_IDLE;
        end else if (slide_p) begin
          w_half_next = ~r_half;
        end else if (up_p ^ down_p) begin
          w_digits_next = w_edit_digits;
        end
      end
      S_SET_WAIT: begin
        if (!pw_set) w_state_next = S_IDLE;
      end
      S_FAIL: begin
        if (w_res_exp) w_state_next = w_lock_due ? S_LOCK : S_IDLE;
      end
      S_LOCK: begin
        if (w_lock_exp) begin
          w_state_next = S_IDLE;
          w_fail_next  = 2'd0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_timer_next = r_timer;
    if (w_state_next != r_state) w_timer_next = 12'd0;
    else if (tick_100hz)         w_timer_next = r_timer + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_digits   <= 16'h0000;
      r_pw       <= 16'h0000;
      r_half     <= 1'b0;
      r_place    <= 1'b0;
      r_timer    <= 12'd0;
      r_fail_cnt <= 2'd0;
      r_led_g    <= 1'b0;
      r_led_r    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_digits   <= w_digits_next;
      r_pw       <= w_pw_next;
      r_half     <= w_half_next;
      r_place    <= place;
      r_timer    <= w_timer_next;
      r_fail_cnt <= w_fail_next;
      r_led_g    <= (w_state_next == S_OPEN) || (w_state_next == S_SET);
      r_led_r    <= (w_state_next == S_FAIL) || (w_state_next == S_LOCK);
    end
  end

  assign disp_digits = r_digits;
  assign cursor      = {r_place, r_half};
  assign led_g       = r_led_g;
  assign led_r       = r_led_r;
  assign state       = r_state;
  assign fail_cnt    = r_fail_cnt;

endmodule
